// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, mem, writeback.
// Owns PC/IR, gates decoder strobes to once per instruction, and traps faults.
module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  input  logic [6:0]  dec_operation,
  input  logic        dec_rf_wr_en,
  input  logic        dec_dmem_wr_en,
  input  logic        dec_pc_in_mux_sel,
  input  logic [31:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_wr_en,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] retired_count
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       retired_q, retired_d;
  logic              fault_q, fault_d;

  logic legal_op;
  logic mem_op;
  logic misaligned;
  logic wait_expired;

  // Opcode classification from the decoder
  always_comb begin
    legal_op = 1'b0;
    case (dec_operation)
      OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR,
      OP_LUI, OP_BRANCH, OP_STORE, OP_LOAD: legal_op = 1'b1;
      default:                              legal_op = 1'b0;
    endcase
  end

  assign mem_op       = (dec_operation == OP_LOAD) || (dec_operation == OP_STORE);
  assign misaligned   = dec_pc_in_mux_sel && (branch_target[1:0] != 2'b00);
  assign wait_expired = (wait_q == WAIT_LIMIT);

  // Next-state and datapath-register update
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    fault_d   = fault_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = legal_op ? S_EXECUTE : S_FAULT;
      end
      S_EXECUTE: begin
        if (mem_op) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WRITEBACK;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        // A misaligned target retires nothing and leaves PC pointing at the culprit
        if (misaligned) begin
          state_d = S_FAULT;
        end else begin
          pc_d      = dec_pc_in_mux_sel ? branch_target : pc_q + 32'd4;
          retired_d = retired_q + 32'd1;
          wait_d    = '0;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (state_d == S_FAULT) fault_d = 1'b1;
  end

  // State and architectural registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSN;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  // Strobes decode straight from state so they drop the instant reset rises
  assign imem_req = ~reset & (state_q == S_FETCH);
  assign dmem_req = ~reset & (state_q == S_MEM);
  assign dmem_we  = ~reset & (state_q == S_MEM) & dec_dmem_wr_en;
  assign rf_wr_en = ~reset & (state_q == S_WRITEBACK) & dec_rf_wr_en & ~misaligned;

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instruction   = ir_q;
  assign state         = state_q;
  assign fault         = fault_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: vector table per instruction with a
// scoreboard of expected outcomes, plus fault-hold and reset-mid-MEM sequences.
module tb_multicycle_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [2:0]  ST_FETCH = 3'd0;
  localparam logic [2:0]  ST_MEM   = 3'd3;
  localparam logic [2:0]  ST_FAULT = 3'd7;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [6:0]  dec_operation;
  logic        dec_rf_wr_en;
  logic        dec_dmem_wr_en;
  logic        dec_pc_in_mux_sel;
  logic [31:0] branch_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_wr_en;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        fault;
  logic [31:0] retired_count;

  multicycle_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instruction(instruction),
    .dec_operation(dec_operation), .dec_rf_wr_en(dec_rf_wr_en),
    .dec_dmem_wr_en(dec_dmem_wr_en), .dec_pc_in_mux_sel(dec_pc_in_mux_sel),
    .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .rf_wr_en(rf_wr_en), .pc(pc), .state(state),
    .fault(fault), .retired_count(retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] word;
    int          iw;      // imem wait cycles before ready
    int          dw;      // dmem wait cycles before ready
    bit          rf;
    bit          dwr;
    bit          sel;
    logic [31:0] tgt;
    int          cycles;  // expected cycles until FETCH again or FAULT
    bit          flt;
  } vec_t;

  typedef struct {
    int          cycles;
    logic [31:0] pc;
    logic [31:0] ret;
    logic [31:0] ir;
    bit          flt;
    int          rf;
    int          ireq;
    int          dreq;
    int          dwe;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("strobes_in_reset", 32'({imem_req, dmem_req, dmem_we, rf_wr_en}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(ST_FETCH));
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", instruction, 32'h0000_0013);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retired", retired_count, 32'd0);
    m_pc  = RESET_PC;
    m_ret = 32'd0;
    m_ir  = 32'h0000_0013;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    bit   is_mem;
    bit   tmo;
    bit   left;
    int   icnt;
    int   dcnt;
    int   rf_out_wb;

    is_mem   = (v.word[6:0] == 7'b0000011) || (v.word[6:0] == 7'b0100011);
    tmo      = (v.iw >= TIMEOUT);
    e.cycles = v.cycles;
    e.flt    = v.flt;
    e.ir     = tmo ? m_ir : v.word;
    e.pc     = v.flt ? m_pc : (v.sel ? v.tgt : m_pc + 32'd4);
    e.ret    = v.flt ? m_ret : m_ret + 32'd1;
    e.rf     = (!v.flt && v.rf) ? 1 : 0;
    e.ireq   = tmo ? TIMEOUT : v.iw + 1;
    e.dreq   = (is_mem && !v.flt) ? v.dw + 1 : 0;
    e.dwe    = v.dwr ? e.dreq : 0;
    sb.push_back(e);
    m_pc  = e.pc;
    m_ret = e.ret;
    m_ir  = e.ir;

    imem_rdata        = v.word;
    dec_operation     = v.word[6:0];
    dec_rf_wr_en      = v.rf;
    dec_dmem_wr_en    = v.dwr;
    dec_pc_in_mux_sel = v.sel;
    branch_target     = v.tgt;
    check({v.name, "_start_state"}, 32'(state), 32'(ST_FETCH));

    got = '{default: 0};
    left = 1'b0;
    icnt = 0;
    dcnt = 0;
    rf_out_wb = 0;
    do begin
      imem_ready = (state == ST_FETCH) && (icnt == v.iw);
      dmem_ready = (state == ST_MEM) && (dcnt == v.dw);
      if (state == ST_FETCH) icnt++;
      if (state == ST_MEM) dcnt++;
      if (imem_req) got.ireq++;
      if (dmem_req) got.dreq++;
      if (dmem_we) got.dwe++;
      if (rf_wr_en) got.rf++;
      if (rf_wr_en && state != 3'd4) rf_out_wb++;
      @(negedge clock);
      got.cycles++;
      if (state != ST_FETCH) left = 1'b1;
    end while (!(left && state == ST_FETCH) && state != ST_FAULT && got.cycles < 64);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    e = sb.pop_front();
    check({v.name, "_cycles"}, 32'(got.cycles), 32'(e.cycles));
    check({v.name, "_imem_req_cycles"}, 32'(got.ireq), 32'(e.ireq));
    check({v.name, "_dmem_req_cycles"}, 32'(got.dreq), 32'(e.dreq));
    check({v.name, "_dmem_we_cycles"}, 32'(got.dwe), 32'(e.dwe));
    check({v.name, "_rf_pulses"}, 32'(got.rf), 32'(e.rf));
    check({v.name, "_rf_outside_wb"}, 32'(rf_out_wb), 32'd0);
    check({v.name, "_fault"}, 32'(fault), 32'(e.flt));
    check({v.name, "_pc"}, pc, e.pc);
    check({v.name, "_imem_addr"}, imem_addr, e.pc);
    check({v.name, "_retired"}, retired_count, e.ret);
    check({v.name, "_ir"}, instruction, e.ir);
  endtask

  // Fault must hold with no strobes and frozen state while memories wave ready
  task automatic fault_hold(input string name);
    int bad;
    bad = 0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (fault !== 1'b1 || imem_req || dmem_req || dmem_we || rf_wr_en ||
          state !== ST_FAULT || pc !== m_pc || retired_count !== m_ret)
        bad++;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check({name, "_fault_hold"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int cyc;

    reset             = 1'b1;
    imem_ready        = 1'b0;
    imem_rdata        = 32'd0;
    dec_operation     = 7'd0;
    dec_rf_wr_en      = 1'b1;
    dec_dmem_wr_en    = 1'b1;
    dec_pc_in_mux_sel = 1'b0;
    branch_target     = 32'd0;
    dmem_ready        = 1'b0;

    //          name        word          iw  dw rf dwr sel tgt            cyc flt
    vecs[0]  = '{"addi",    32'h00500093, 0,  0, 1, 0,  0, 32'h0,          4,  0};
    vecs[1]  = '{"lw",      32'h0000A103, 0,  3, 1, 0,  0, 32'h0,          8,  0};
    vecs[2]  = '{"sw",      32'h0020A023, 2,  0, 0, 1,  0, 32'h0,          7,  0};
    vecs[3]  = '{"beq",     32'h00000063, 0,  0, 0, 0,  1, 32'h0000_0040,  4,  0};
    vecs[4]  = '{"lui_w16", 32'h000010B7, 15, 0, 1, 0,  0, 32'h0,          19, 0};
    vecs[5]  = '{"add",     32'h002081B3, 1,  0, 1, 0,  0, 32'h0,          5,  0};
    vecs[6]  = '{"jal_top", 32'h0000006F, 0,  0, 1, 0,  1, 32'hFFFF_FFFC,  4,  0};
    vecs[7]  = '{"addi_wr", 32'h00500093, 0,  0, 1, 0,  0, 32'h0,          4,  0};
    vecs[8]  = '{"br_mis",  32'h00000063, 0,  0, 1, 0,  1, 32'h0000_0042,  4,  1};
    vecs[9]  = '{"illegal", 32'h0000007F, 0,  0, 1, 1,  0, 32'h0,          2,  1};
    vecs[10] = '{"tmo",     32'h00500093, 99, 0, 1, 0,  0, 32'h0,          16, 1};
    vecs[11] = '{"jalr",    32'h00008067, 0,  0, 1, 0,  1, 32'h0000_0100,  4,  0};

    do_reset();

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (vecs[i].flt) begin
        fault_hold(vecs[i].name);
        do_reset();
      end
    end

    // Reset arriving mid-MEM must kill the data strobes combinationally
    imem_rdata        = 32'h0020A023;
    dec_operation     = 7'b0100011;
    dec_rf_wr_en      = 1'b0;
    dec_dmem_wr_en    = 1'b1;
    dec_pc_in_mux_sel = 1'b0;
    dmem_ready        = 1'b0;
    cyc = 0;
    while (state != ST_MEM && cyc < 20) begin
      imem_ready = (state == ST_FETCH);
      @(negedge clock);
      cyc++;
    end
    imem_ready = 1'b0;
    check("midmem_reached", 32'(state), 32'(ST_MEM));
    @(negedge clock);
    check("midmem_dmem_req", 32'({dmem_req, dmem_we}), 32'd3);
    reset = 1'b1;
    #1;
    check("midmem_req_drop", 32'({dmem_req, dmem_we}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midmem_pc", pc, RESET_PC);
    check("midmem_retired", retired_count, 32'd0);
    check("midmem_state", 32'(state), 32'(ST_FETCH));
    check("midmem_fault", 32'(fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that steps the core datapath through fetch, decode, execute, memory and writeback.
- Owns the PC and the instruction register (IR) and drives the fetched word into the decode-control block.
- Gates the decoder's register-file and data-memory strobes so each fires exactly once per instruction.
- Handshakes with instruction/data memories using req/ready, with a timeout, and flags illegal opcodes and misaligned jumps as a sticky fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYCLES, 16, maximum cycles a memory request may wait for ready before fault (>=1).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  32  fetch address, equals pc.
imem_ready  input  1  fetch data valid this cycle.
imem_rdata  input  32  fetched instruction word.
instruction  output  32  IR contents, fed to the decoder.
dec_operation  input  7  opcode from the decoder (instruction[6:0]).
dec_rf_wr_en  input  1  decoder register-file write enable (ungated).
dec_dmem_wr_en  input  1  decoder store enable (ungated).
dec_pc_in_mux_sel  input  1  decoder jump/branch-taken select.
branch_target  input  32  jump/branch target from the datapath.
dmem_req  output  1  data memory request.
dmem_we  output  1  data memory write strobe.
dmem_ready  input  1  data access complete.
rf_wr_en  output  1  gated register-file write enable.
pc  output  32  current program counter.
state  output  3  current FSM state encoding.
fault  output  1  sticky fault flag.
retired_count  output  32  count of retired instructions.

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, instruction=32'h0000_0013 (NOP), state=FETCH, fault=0, retired_count=0, wait counter=0.
  - imem_req, dmem_req, dmem_we and rf_wr_en are all 0 while reset is high.
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, FAULT=7. Codes 5 and 6 are unused and decode to FAULT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: IR<=imem_rdata, go to DECODE.
- DECODE (1 cycle):
  - Legal opcodes are 0110011, 0010011, 1101111, 1100111, 0110111, 1100011, 0100011, 0000011.
  - Any other dec_operation goes to FAULT; otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - Opcode 0000011 (load) or 0100011 (store) goes to MEM; all others go to WRITEBACK.
- MEM:
  - dmem_req=1 and dmem_we=dec_dmem_wr_en, both held until dmem_ready.
  - On dmem_ready go to WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_wr_en=dec_rf_wr_en, asserted only in this state.
  - pc<=dec_pc_in_mux_sel ? branch_target : pc+4 (32-bit wrap: 32'hFFFF_FFFC+4=0).
  - retired_count increments (wraps), then go to FETCH.
- Misaligned target: in WRITEBACK with dec_pc_in_mux_sel=1 and branch_target[1:0]!=0:
  - rf_wr_en is forced 0, pc holds, retired_count holds.
  - Go to FAULT.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle the request is pending without ready.
  - ready on the Nth request cycle is accepted for N<=TIMEOUT_CYCLES; ready wins if coincident with the limit.
  - No ready by the end of cycle TIMEOUT_CYCLES goes to FAULT.
- FAULT:
  - fault=1 and all strobes 0; pc, IR and retired_count frozen.
  - Exits only on reset.
- Latency with zero-wait memories: ALU/jump/branch/LUI = 4 cycles, load/store = 5 cycles. Each wait cycle adds 1.
- All outputs are registered except the strobes, which decode combinationally from state (and decoder inputs) gated by ~reset.
- Decoder inputs are sampled only in the states that use them; changes elsewhere are ignored.

Test Plan:
- Reset, zero-wait imem, imem_rdata=0x00500093 (addi), dec_rf_wr_en=1 -> states 0,1,2,4; rf_wr_en high only in cycle 4; pc=4; retired_count=1.
- lw 0x0000A103 with dmem_ready after 3 wait cycles, dec_dmem_wr_en=0 -> dmem_req high 4 cycles with dmem_we=0, then one rf_wr_en pulse; 8 cycles total; pc=4.
- Taken branch, dec_pc_in_mux_sel=1, branch_target=0x40 -> pc=0x40. Repeat with target 0x42 -> fault=1, pc unchanged, rf_wr_en never asserted.
- Illegal word 0x0000007F -> FAULT the cycle after DECODE; fault stays 1 with no strobes for 20 cycles; reset clears it, pc=RESET_PC.
- TIMEOUT_CYCLES=16, imem_ready never asserted -> imem_req high exactly 16 cycles, then fault. Rerun with ready on cycle 16 -> fetch accepted, no fault.
- Reset asserted mid-MEM -> dmem_req drops immediately (same cycle); after release pc=RESET_PC, retired_count=0, state=FETCH.
